neuron_layer_pingpong: RTL

NEURON_LAYER_PINGPONG -- requirements
Module: neuron_layer_pingpong

---
 rtl/neuron_layer_pingpong.sv | 124 ++++++++++++
 1 files changed

// File: rtl/neuron_layer_pingpong.sv
// Double-buffered neuron layer store: writes fill a shadow bank while the consumer
// reads the active bank; a commit swaps them once the consumer has released the active one.
module neuron_layer_pingpong #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned LAYER_SZ = 2,
  parameter int unsigned ADDR_W   = $clog2(LAYER_SZ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [SIZE-1:0]                    wr_value,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic                               wr_addr_sel,
  input  logic                               wr_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LAYER_SZ-1:0][SIZE-1:0]      values,
  output logic                               addr_err
);

  localparam int unsigned PTR_W = $clog2(LAYER_SZ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAYER_SZ - 1);

  typedef enum logic {FILL, PEND} state_e;

  state_e                             state_q, state_d;
  logic                               sel_q, sel_d;
  logic [1:0][LAYER_SZ-1:0][SIZE-1:0] bank_q, bank_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic                               ovalid_q, ovalid_d;
  logic                               err_q, err_d;

  logic accept;
  logic commit;
  logic swap;
  logic bank_free;

  // State register; reset clears both banks and any partial or pending fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      sel_q    <= 1'b0;
      bank_q   <= '0;
      ptr_q    <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      bank_q   <= bank_d;
      ptr_q    <= ptr_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  // Next state: the write lands in the shadow bank first, so a swap on the
  // same edge publishes it together with the rest of the layer.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    bank_d    = bank_q;
    ptr_d     = ptr_q;
    ovalid_d  = ovalid_q;
    err_d     = err_q;
    commit    = 1'b0;
    swap      = 1'b0;
    bank_free = !ovalid_q || out_ready;
    accept    = wr_valid && (state_q == FILL);

    if (accept) begin
      if (wr_addr_sel) begin
        if (32'(wr_addr) < LAYER_SZ) begin
          bank_d[~sel_q][wr_addr] = wr_value;
        end else begin
          err_d = 1'b1;
        end
        commit = wr_last;
      end else begin
        bank_d[~sel_q][ptr_q] = wr_value;
        ptr_d  = ptr_q + PTR_W'(1);
        commit = wr_last || (ptr_q == PTR_LAST);
      end
      if (commit) begin
        ptr_d = '0;
      end
    end

    case (state_q)
      FILL: begin
        if (commit) begin
          if (bank_free) begin
            swap = 1'b1;
          end else begin
            state_d = PEND;
          end
        end else if (ovalid_q && out_ready) begin
          ovalid_d = 1'b0;
        end
      end
      PEND: begin
        if (out_ready) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Outgoing active bank is wiped so it re-enters service as a clean shadow.
    if (swap) begin
      sel_d         = ~sel_q;
      bank_d[sel_q] = '0;
      ovalid_d      = 1'b1;
    end
  end

  assign wr_ready  = (state_q == FILL);
  assign out_valid = ovalid_q;
  assign values    = bank_q[sel_q];
  assign addr_err  = err_q;

endmodule
